// File: rtl/dec2bin_pkg.sv
// dec2bin_pkg: shared state encoding and ASCII constants for the decimal-to-binary converter.
package dec2bin_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/dec2bin_accum_if.sv
// dec2bin_accum_if: byte-in / result-out handshake bundle for the decimal converter.
interface dec2bin_accum_if #(parameter int WIDTH = 32);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_value;
    logic [3:0]       out_digits;
    logic             out_overflow;
    logic             out_error;
    logic             out_valid;
    logic             out_ready;
    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_value, out_digits, out_overflow, out_error, out_valid);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_value, out_digits, out_overflow, out_error, out_valid);
endinterface

// File: rtl/mul10_add.sv
// mul10_add: acc*10 + digit at WIDTH+4 bits, saturating to all-ones when the top nibble is set.
module mul10_add #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);
    logic [WIDTH+3:0] wide;
    assign wide = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{WIDTH{1'b0}}, digit};
    assign ovf  = |wide[WIDTH+3:WIDTH];
    assign sum  = ovf ? '1 : wide[WIDTH-1:0];
endmodule

// File: rtl/dec2bin_accum.sv
// dec2bin_accum: accumulates an ASCII decimal byte stream into one binary result per CR/LF-terminated number.
module dec2bin_accum
    import dec2bin_pkg::*;
#(parameter int WIDTH = 32) (
    input logic         clk,
    input logic         reset,
    dec2bin_accum_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] acc, sum;
    logic [3:0]       digits;
    logic             ovf, err, mul_ovf, fire, is_digit, is_term;
    assign fire     = bus.in_valid && bus.in_ready;
    assign is_digit = bus.in_data >= ASCII_0 && bus.in_data <= ASCII_9;
    assign is_term  = bus.in_data == ASCII_CR || bus.in_data == ASCII_LF;
    mul10_add #(.WIDTH(WIDTH)) u_mul (.acc(acc), .digit(bus.in_data[3:0]), .sum(sum), .ovf(mul_ovf));
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            acc              <= '0;
            digits           <= '0;
            ovf              <= 1'b0;
            err              <= 1'b0;
            bus.in_ready     <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_value    <= '0;
            bus.out_digits   <= '0;
            bus.out_overflow <= 1'b0;
            bus.out_error    <= 1'b0;
        end else begin
            case (state)
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    acc           <= '0;
                    digits        <= '0;
                    ovf           <= 1'b0;
                    err           <= 1'b0;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
                default: begin
                    bus.in_ready <= 1'b1;
                    if (fire && is_digit) begin
                        // once saturated, later digits must not bring the value back below all-ones
                        acc    <= ovf ? '1 : sum;
                        ovf    <= ovf | mul_ovf;
                        digits <= digits + {3'b0, digits != 4'hF};
                        state  <= ACCUM;
                    end else if (fire && is_term && state == ACCUM) begin
                        state            <= DONE;
                        bus.out_value    <= acc;
                        bus.out_digits   <= digits;
                        bus.out_overflow <= ovf;
                        bus.out_error    <= err;
                        bus.out_valid    <= 1'b1;
                        bus.in_ready     <= 1'b0;
                    end else if (fire && !is_term) begin
                        err   <= 1'b1;
                        state <= ACCUM;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dec2bin_accum.sv
// tb_dec2bin_accum: directed and random ASCII streams checked against an arithmetic reference model.
module tb_dec2bin_accum;
    typedef struct packed {logic [31:0] v; logic [3:0] d; logic o; logic e;} res_t;
    logic clk = 0;
    logic reset = 1;
    int total = 0, bad = 0, n_res = 0, cyc = 0, hs_cyc = 0, ac_cyc = 0;
    bit rnd = 0, was_hs = 0;
    res_t q[$];
    res_t last;
    logic [63:0] mv;
    bit mo, me, mact;
    int md;
    logic [31:0] m_acc, m_sum;
    logic [3:0]  m_dig;
    logic        m_ovf;
    logic [7:0]  junk [4] = '{8'h78, 8'h20, 8'h2D, 8'hFF};

    dec2bin_accum_if ifc ();
    dec2bin_accum dut (.clk(clk), .reset(reset), .bus(ifc));
    mul10_add #(.WIDTH(32)) u_mul (.acc(m_acc), .digit(m_dig), .sum(m_sum), .ovf(m_ovf));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        mv = 0; mo = 0; me = 0; md = 0; mact = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) begin
            if (!mo) begin
                mv = mv * 10 + 64'(b - 8'h30);
                if (mv > 64'hFFFF_FFFF) mo = 1;
            end
            md = (md < 15) ? md + 1 : 15;
            mact = 1;
        end else if (b == 8'h0D || b == 8'h0A) begin
            if (mact) q.push_back('{mo ? 32'hFFFF_FFFF : mv[31:0], 4'(md), mo, me});
            if (mact) model_clear();
        end else begin
            me = 1;
            mact = 1;
        end
    endtask

    always @(negedge clk) begin
        res_t e;
        if (was_hs) check("valid_drop", 64'(ifc.out_valid), 0);
        was_hs = !reset && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1;
        if (was_hs) begin
            n_res++;
            hs_cyc = cyc;
            last = '{ifc.out_value, ifc.out_digits, ifc.out_overflow, ifc.out_error};
            if (q.size() == 0) check("extra_result", 1, 0);
            else begin
                e = q.pop_front();
                check("value", 64'(ifc.out_value), 64'(e.v));
                check("digits", 64'(ifc.out_digits), 64'(e.d));
                check("overflow", 64'(ifc.out_overflow), 64'(e.o));
                check("error", 64'(ifc.out_error), 64'(e.e));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        logic ok = 0;
        ifc.in_valid = 1;
        ifc.in_data = b;
        while (!ok && n < 200) begin
            if (rnd) ifc.out_ready = ($urandom % 3) != 0;
            @(negedge clk);
            ok = ifc.in_ready;
            if (ok) ac_cyc = cyc;
            n++;
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", 0, 1);
        else model_byte(b);
        ifc.in_valid = 0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic expect_last(input string tag, input logic [31:0] v, input logic [3:0] d, input logic o, input logic e);
        check({tag, "_v"}, 64'(last.v), 64'(v));
        check({tag, "_d"}, 64'(last.d), 64'(d));
        check({tag, "_o"}, 64'(last.o), 64'(o));
        check({tag, "_e"}, 64'(last.e), 64'(e));
    endtask

    task automatic do_reset();
        ifc.in_valid = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(ifc.in_ready), 0);
        check("rst_out_valid", 64'(ifc.out_valid), 0);
        check("rst_out_value", 64'(ifc.out_value), 0);
        check("rst_flags", 64'({ifc.out_digits, ifc.out_overflow, ifc.out_error}), 0);
        reset = 0;
        model_clear();
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_rst", 64'(ifc.in_ready), 1);
    endtask

    initial begin
        int n0;
        logic [31:0] b_acc [4] = '{32'd429496729, 32'd429496729, 32'hFFFF_FFFF, 32'd0};
        logic [3:0]  b_dig [4] = '{4'd5, 4'd6, 4'd0, 4'd9};
        logic [63:0] ex;
        ifc.in_valid = 0;
        ifc.in_data = 0;
        ifc.out_ready = 1;
        model_clear();
        for (int i = 0; i < 40; i++) begin
            m_acc = (i < 4) ? b_acc[i] : ((i % 2) ? $urandom : $urandom_range(0, 500000000));
            m_dig = (i < 4) ? b_dig[i] : 4'($urandom_range(0, 9));
            #1;
            ex = 64'(m_acc) * 10 + 64'(m_dig);
            check("mul_ovf", 64'(m_ovf), 64'(ex > 64'hFFFF_FFFF));
            check("mul_sum", 64'(m_sum), ex > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : ex);
        end
        do_reset();

        send_str("1234\015"); settle();
        expect_last("d1234", 32'd1234, 4'd4, 0, 0);
        send_str("4294967295\n"); settle();
        expect_last("max", 32'hFFFF_FFFF, 4'd10, 0, 0);
        send_str("4294967296\n"); settle();
        expect_last("ovf1", 32'hFFFF_FFFF, 4'd10, 1, 0);
        send_str("99999999999\n"); settle();
        expect_last("ovf2", 32'hFFFF_FFFF, 4'd11, 1, 0);
        n0 = n_res;
        send_str("\015\n12\015\n\015\n"); settle();
        check("crlf_count", 64'(n_res - n0), 1);
        expect_last("crlf", 32'd12, 4'd2, 0, 0);
        send_str("1a2\015"); settle();
        expect_last("junk", 32'd12, 4'd2, 0, 1);
        send_str("7\015"); settle();
        expect_last("clear", 32'd7, 4'd1, 0, 0);
        send_str("x\015"); settle();
        expect_last("xonly", 32'd0, 4'd0, 0, 1);
        send_str("0000000000000000042\n"); settle();
        expect_last("lead0", 32'd42, 4'd15, 0, 0);

        ifc.out_ready = 0;
        send_str("56\015");
        ifc.in_valid = 1;
        ifc.in_data = 8'h39;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(ifc.in_ready), 0);
            check("bp_value", 64'(ifc.out_value), 56);
            @(posedge clk);
            #1;
        end
        ifc.out_ready = 1;
        send_byte(8'h39);
        check("bp_gap", 64'(ac_cyc - hs_cyc), 1);
        send_str("\015"); settle();
        expect_last("bp9", 32'd9, 4'd1, 0, 0);

        send_str("123");
        do_reset();
        send_str("4\015"); settle();
        expect_last("midrst", 32'd4, 4'd1, 0, 0);
        ifc.out_ready = 0;
        n0 = n_res;
        send_str("5\015");
        @(negedge clk);
        check("done_hold", 64'(ifc.out_valid), 1);
        do_reset();
        ifc.out_ready = 1;
        settle();
        check("dropped", 64'(n_res - n0), 0);

        rnd = 1;
        for (int k = 0; k < 60; k++) begin
            int len = $urandom_range(0, 12);
            for (int j = 0; j < len; j++) begin
                int r = $urandom % 20;
                send_byte(r < 19 ? 8'(8'h30 + $urandom_range(0, 9)) : junk[$urandom % 4]);
            end
            case ($urandom % 3)
                0: send_byte(8'h0D);
                1: send_byte(8'h0A);
                default: begin send_byte(8'h0D); send_byte(8'h0A); end
            endcase
        end
        rnd = 0;
        ifc.out_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        check("drain", 64'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
